spi_sensor_scheduler: RTL and testbench

Shares one SPI sensor bus (SCLK/SDO, one active-low chip select per sensor) between several 8-bit ADC sensor channels in the basement monitoring system. The block schedules periodic scans and on-demand reads, arbitrates between channels round-robin, and runs each 16-bit read frame. It returns the extracted 8-bit sample tagged with its channel. Everything is synchronous to clk_12M; SCLK is a generated, registered output, not a derived clock.

---
 rtl/spi_sensor_scheduler.sv | 187 ++++++++++++++++++
 tb/tb_spi_sensor_scheduler.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_sensor_scheduler.sv
// Shared SPI sensor bus scheduler: periodic scans plus on-demand reads,
// round-robin arbitration and 16-bit read frames returning an 8-bit sample.
module spi_sensor_scheduler #(
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned SCLK_DIV   = 4,
  parameter int unsigned FRAME_BITS = 16,
  parameter int unsigned DATA_MSB   = 12,
  parameter int unsigned DATA_LSB   = 5,
  parameter int unsigned PERIOD     = 1200000,
  localparam int unsigned CHW       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_12M,
  input  logic              reset,
  input  logic              enable,
  input  logic [NUM_CH-1:0] ch_mask,
  input  logic [NUM_CH-1:0] req,
  input  logic              sdo,
  output logic              sclk,
  output logic [NUM_CH-1:0] cs_n,
  output logic [7:0]        data_out,
  output logic [CHW-1:0]    ch_out,
  output logic              data_valid,
  output logic              busy,
  output logic              overrun
);

  localparam int unsigned HALF = SCLK_DIV / 2;
  localparam int unsigned CW   = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam int unsigned BW   = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
  localparam int unsigned TW   = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SETUP = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;
  localparam logic [1:0] HOLD  = 2'd3;

  logic [1:0]          state, state_nx;
  logic [CW-1:0]       cnt, cnt_nx;
  logic [BW-1:0]       bit_cnt, bit_cnt_nx;
  logic [DATA_MSB:0]   frame, frame_nx;
  logic [CHW-1:0]      cur_ch, cur_ch_nx;
  logic [CHW-1:0]      rr_ptr, rr_ptr_nx;
  logic                sclk_nx, busy_nx, data_valid_nx;
  logic [NUM_CH-1:0]   cs_n_nx;
  logic [7:0]          data_out_nx;
  logic [CHW-1:0]      ch_out_nx;

  logic [TW-1:0]       timer;
  logic                tick;
  logic [NUM_CH-1:0]   pending;
  logic [NUM_CH-1:0]   grant_oh;
  logic                grant_found;
  logic [CHW-1:0]      grant_idx;
  logic [CHW-1:0]      cand;

  assign tick = enable && (timer == TW'(PERIOD - 1));

  // Round-robin search: first pending channel at or above the pointer, wrapping.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      cand = CHW'((32'(rr_ptr) + i) % NUM_CH);
      if (!grant_found && pending[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Scan timer, pending request vector and sticky overrun flag.
  always_ff @(posedge clk_12M or posedge reset) begin
    if (reset) begin
      timer   <= '0;
      pending <= '0;
      overrun <= 1'b0;
    end else if (!enable) begin
      timer   <= '0;
      pending <= '0;
    end else begin
      timer   <= tick ? '0 : timer + TW'(1);
      pending <= (pending & ~grant_oh) | (tick ? ch_mask : '0) | req;
      if (tick && ((pending & ch_mask) != '0)) overrun <= 1'b1;
    end
  end

  // Next-state and next-output logic for the frame sequencer.
  always_comb begin
    state_nx      = state;
    cnt_nx        = cnt + CW'(1);
    bit_cnt_nx    = bit_cnt;
    frame_nx      = frame;
    cur_ch_nx     = cur_ch;
    rr_ptr_nx     = rr_ptr;
    sclk_nx       = sclk;
    cs_n_nx       = cs_n;
    busy_nx       = busy;
    data_valid_nx = 1'b0;
    data_out_nx   = data_out;
    ch_out_nx     = ch_out;
    grant_oh      = '0;
    case (state)
      IDLE: begin
        cnt_nx  = '0;
        sclk_nx = 1'b1;
        cs_n_nx = '1;
        busy_nx = 1'b0;
        if (enable && grant_found) begin
          grant_oh  = NUM_CH'(1) << grant_idx;
          state_nx  = SETUP;
          cs_n_nx   = ~(NUM_CH'(1) << grant_idx);
          busy_nx   = 1'b1;
          cur_ch_nx = grant_idx;
          rr_ptr_nx = CHW'((32'(grant_idx) + 32'd1) % NUM_CH);
        end
      end
      SETUP: begin
        if (cnt == CW'(HALF - 1)) begin
          state_nx   = SHIFT;
          cnt_nx     = '0;
          bit_cnt_nx = '0;
          sclk_nx    = 1'b0;
        end
      end
      SHIFT: begin
        if (cnt == CW'(HALF - 1)) begin
          sclk_nx  = 1'b1;
          frame_nx = {frame[DATA_MSB-1:0], sdo};
        end
        if (cnt == CW'(SCLK_DIV - 1)) begin
          cnt_nx = '0;
          if (bit_cnt == BW'(FRAME_BITS - 1)) begin
            state_nx      = HOLD;
            cs_n_nx       = '1;
            data_valid_nx = 1'b1;
            data_out_nx   = 8'(frame[DATA_MSB:DATA_LSB]);
            ch_out_nx     = cur_ch;
          end else begin
            bit_cnt_nx = bit_cnt + BW'(1);
            sclk_nx    = 1'b0;
          end
        end
      end
      HOLD: begin
        if (cnt == CW'(SCLK_DIV - 1)) begin
          state_nx = IDLE;
          cnt_nx   = '0;
          busy_nx  = 1'b0;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk_12M or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_cnt    <= '0;
      frame      <= '0;
      cur_ch     <= '0;
      rr_ptr     <= '0;
      sclk       <= 1'b1;
      cs_n       <= '1;
      busy       <= 1'b0;
      data_valid <= 1'b0;
      data_out   <= '0;
      ch_out     <= '0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      bit_cnt    <= bit_cnt_nx;
      frame      <= frame_nx;
      cur_ch     <= cur_ch_nx;
      rr_ptr     <= rr_ptr_nx;
      sclk       <= sclk_nx;
      cs_n       <= cs_n_nx;
      busy       <= busy_nx;
      data_valid <= data_valid_nx;
      data_out   <= data_out_nx;
      ch_out     <= ch_out_nx;
    end
  end

endmodule

// File: tb/tb_spi_sensor_scheduler.sv
// Self-checking bench for spi_sensor_scheduler (two channels, short scan period).
module tb_spi_sensor_scheduler;

  localparam int NUM_CH = 2;
  localparam int FB     = 16;

  logic        clk_12M = 1'b0;
  logic        reset   = 1'b1;
  logic        enable  = 1'b0;
  logic [1:0]  ch_mask = '0;
  logic [1:0]  req     = '0;
  logic        sdo     = 1'b0;
  logic        sclk;
  logic [1:0]  cs_n;
  logic [7:0]  data_out;
  logic        ch_out;
  logic        data_valid;
  logic        busy;
  logic        overrun;

  spi_sensor_scheduler #(
    .NUM_CH(2), .SCLK_DIV(4), .FRAME_BITS(16),
    .DATA_MSB(12), .DATA_LSB(5), .PERIOD(60)
  ) dut (
    .clk_12M(clk_12M), .reset(reset), .enable(enable), .ch_mask(ch_mask),
    .req(req), .sdo(sdo), .sclk(sclk), .cs_n(cs_n), .data_out(data_out),
    .ch_out(ch_out), .data_valid(data_valid), .busy(busy), .overrun(overrun)
  );

  always #5 clk_12M = ~clk_12M;

  typedef struct { int ch; logic [7:0] data; } exp_t;
  typedef struct { int ch; logic [15:0] word; logic [7:0] exp; } vec_t;

  int n_cmp = 0;
  int n_bad = 0;
  exp_t exp_q[$];
  int   grant_log[$];
  int   fall_t[$];
  logic [15:0] chan_word [NUM_CH];
  logic [7:0]  chan_exp  [NUM_CH];
  int   dv_count = 0;
  int   cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk_12M);
    #1;
  endtask

  task automatic pulse_req(input logic [1:0] r);
    req = r;
    step(1);
    req = '0;
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    req   = '0;
    step(3);
    reset = 1'b0;
    step(1);
  endtask

  task automatic wait_dv(input int n, input int budget, input string name);
    int target;
    int c;
    target = dv_count + n;
    c = 0;
    while (dv_count < target && c < budget) begin
      step(1);
      c++;
    end
    chk(name, 32'(dv_count >= target), 1);
  endtask

  // Bus monitor, sensor model and scoreboard; samples on the falling clock edge.
  logic [1:0] cs_prev   = '1;
  logic       sclk_prev = 1'b1;
  bit         active    = 1'b0;
  int         low_cnt, rise_cnt, bit_idx, cur_ch;
  always @(negedge clk_12M) begin
    cyc++;
    if (reset) begin
      if (active && exp_q.size() > 0) exp_q.delete(exp_q.size() - 1);
      active    = 1'b0;
      cs_prev   = '1;
      sclk_prev = 1'b1;
    end else begin
      chk("cs_at_most_one_low", 32'($countones(~cs_n) <= 1), 1);
      if (cs_prev == 2'b11 && cs_n != 2'b11) begin
        cur_ch = 0;
        for (int i = 0; i < NUM_CH; i++) if (!cs_n[i]) cur_ch = i;
        exp_q.push_back('{ch: cur_ch, data: chan_exp[cur_ch]});
        grant_log.push_back(cur_ch);
        fall_t.push_back(cyc);
        active   = 1'b1;
        low_cnt  = 0;
        rise_cnt = 0;
        bit_idx  = FB - 1;
      end
      if (active && cs_n != 2'b11) begin
        low_cnt++;
        if (sclk && !sclk_prev) rise_cnt++;
        if (!sclk && sclk_prev && bit_idx >= 0) begin
          sdo = chan_word[cur_ch][bit_idx];
          bit_idx--;
        end
      end
      if (active && cs_n == 2'b11) begin
        chk("cs_low_cycles", 32'(low_cnt), 66);
        chk("sclk_rises", 32'(rise_cnt), 16);
        chk("dv_on_cs_rise", 32'(data_valid), 1);
        active = 1'b0;
      end
      if (data_valid) begin
        dv_count++;
        chk("dv_expected", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          exp_t e;
          e = exp_q.pop_front();
          chk("sb_data", 32'(data_out), 32'(e.data));
          chk("sb_ch", 32'(ch_out), 32'(e.ch));
        end
      end
      cs_prev   = cs_n;
      sclk_prev = sclk;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t vecs [7];
    logic [1:0] r;
    int f0, g0, d0, n, quiet;

    vecs[0] = '{ch: 0, word: 16'h0A50, exp: 8'h52};
    vecs[1] = '{ch: 1, word: 16'hFFFF, exp: 8'hFF};
    vecs[2] = '{ch: 0, word: 16'h0000, exp: 8'h00};
    vecs[3] = '{ch: 1, word: 16'hE01F, exp: 8'h00};
    vecs[4] = '{ch: 0, word: 16'h1FE0, exp: 8'hFF};
    vecs[5] = '{ch: 1, word: 16'h1000, exp: 8'h80};
    vecs[6] = '{ch: 0, word: 16'h0020, exp: 8'h01};
    for (int i = 0; i < NUM_CH; i++) begin
      chan_word[i] = 16'h0A50;
      chan_exp[i]  = 8'h52;
    end

    // Reset values
    reset_dut();
    chk("rst_sclk", 32'(sclk), 1);
    chk("rst_cs_n", 32'(cs_n), 3);
    chk("rst_data_out", 32'(data_out), 0);
    chk("rst_ch_out", 32'(ch_out), 0);
    chk("rst_data_valid", 32'(data_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_overrun", 32'(overrun), 0);

    // Periodic scan of channel 0 only
    enable  = 1'b1;
    ch_mask = 2'b01;
    f0 = fall_t.size();
    wait_dv(1, 200, "scan_dv_timeout");
    enable  = 1'b0;
    ch_mask = 2'b00;
    chk("scan_data", 32'(data_out), 32'h52);
    chk("scan_ch", 32'(ch_out), 0);
    step(10);
    chk("scan_one_frame", 32'(fall_t.size() - f0), 1);
    enable = 1'b1;

    // Table-driven on-demand reads
    for (int i = 0; i < 7; i++) begin
      chan_word[vecs[i].ch] = vecs[i].word;
      chan_exp[vecs[i].ch]  = vecs[i].exp;
      r = '0;
      r[vecs[i].ch] = 1'b1;
      pulse_req(r);
      wait_dv(1, 200, "vec_dv_timeout");
      chk("vec_data", 32'(data_out), 32'(vecs[i].exp));
      chk("vec_ch", 32'(ch_out), 32'(vecs[i].ch));
      step(8);
    end

    // Simultaneous requests from reset: ch0 then ch1, 71 cycles apart
    reset_dut();
    enable = 1'b1;
    chan_word[0] = 16'h0A50; chan_exp[0] = 8'h52;
    chan_word[1] = 16'hE01F; chan_exp[1] = 8'h00;
    f0 = fall_t.size();
    g0 = grant_log.size();
    pulse_req(2'b11);
    wait_dv(2, 300, "sim_dv_timeout");
    chk("sim_grant_count", 32'(grant_log.size() - g0), 2);
    if (grant_log.size() - g0 >= 2) begin
      chk("sim_first_ch", 32'(grant_log[g0]), 0);
      chk("sim_second_ch", 32'(grant_log[g0 + 1]), 1);
      chk("sim_fall_gap", 32'(fall_t[f0 + 1] - fall_t[f0]), 71);
    end
    step(10);

    // Round-robin under continuous contention
    g0 = grant_log.size();
    for (int k = 0; k < 50; k++) begin
      pulse_req(2'b11);
      step(9);
    end
    quiet = 0;
    n = 0;
    while (quiet < 80 && n < 600) begin
      step(1);
      n++;
      quiet = busy ? 0 : quiet + 1;
    end
    chk("rr_drain_timeout", 32'(quiet >= 80), 1);
    chk("rr_enough_grants", 32'(grant_log.size() - g0 >= 6), 1);
    if (grant_log.size() > g0) chk("rr_first_ch", 32'(grant_log[g0]), 0);
    for (int k = g0 + 1; k < grant_log.size(); k++)
      chk("rr_alternate", 32'(grant_log[k] != grant_log[k - 1]), 1);

    // Overrun at the second scan tick, sticky until reset
    reset_dut();
    enable  = 1'b1;
    ch_mask = 2'b11;
    step(100);
    chk("ovr_before_tick2", 32'(overrun), 0);
    step(40);
    chk("ovr_after_tick2", 32'(overrun), 1);
    d0 = dv_count;
    step(200);
    chk("ovr_dv_continues", 32'(dv_count > d0), 1);
    chk("ovr_sticky", 32'(overrun), 1);
    ch_mask = 2'b00;
    enable  = 1'b0;
    step(80);
    chk("ovr_sticky_disabled", 32'(overrun), 1);
    reset_dut();
    chk("ovr_cleared_by_reset", 32'(overrun), 0);

    // Reset 30 cycles into SHIFT
    enable = 1'b1;
    chan_word[0] = 16'hFFFF; chan_exp[0] = 8'hFF;
    d0 = dv_count;
    pulse_req(2'b01);
    n = 0;
    while (cs_n[0] !== 1'b0 && n < 20) begin
      step(1);
      n++;
    end
    chk("rst_mid_cs_low", 32'(cs_n[0]), 0);
    step(32);
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_sclk", 32'(sclk), 1);
    chk("rst_mid_cs_n", 32'(cs_n), 3);
    chk("rst_mid_busy", 32'(busy), 0);
    chk("rst_mid_dv", 32'(data_valid), 0);
    chk("rst_mid_data", 32'(data_out), 0);
    step(5);
    reset = 1'b0;
    step(2);
    chk("rst_mid_no_dv", 32'(dv_count - d0), 0);
    chan_word[1] = 16'h5555; chan_exp[1] = 8'hAA;
    pulse_req(2'b10);
    wait_dv(1, 200, "rst_after_dv_timeout");
    chk("rst_after_data", 32'(data_out), 32'hAA);
    chk("rst_after_ch", 32'(ch_out), 1);
    step(10);

    // Enable dropped mid-frame: frame completes, then bus stays quiet
    chan_word[1] = 16'h1000; chan_exp[1] = 8'h80;
    pulse_req(2'b10);
    n = 0;
    while (cs_n[1] !== 1'b0 && n < 20) begin
      step(1);
      n++;
    end
    chk("en_cs_low", 32'(cs_n[1]), 0);
    step(20);
    enable = 1'b0;
    wait_dv(1, 100, "en_dv_timeout");
    chk("en_data", 32'(data_out), 32'h80);
    step(8);
    f0 = fall_t.size();
    for (int k = 0; k < 10; k++) begin
      pulse_req(2'b11);
      step(10);
    end
    chk("en_no_new_frames", 32'(fall_t.size() - f0), 0);
    chk("en_cs_idle", 32'(cs_n), 3);
    chk("en_not_busy", 32'(busy), 0);

    chk("sb_empty", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
